// File: rtl/fluid_board_soc_onchip_memory_dp.sv
// fluid_board_soc_onchip_memory_dp
//
// True-dual-port on-chip RAM with two Avalon-MM slaves (s1, s2).
// After reset an optional clear engine writes zeros through port 1, one word
// per cycle, before the ports start accepting commands.
//
// Optional feature macro: FLUID_ONCHIP_MEM_PARITY_EN
//   defined   : each byte is stored with an even-parity bit, and parity_errx
//               flags a mismatch on read, aligned with readdatavalidx.
//   undefined : the array is DATA_W wide and parity_err1/2 are tied to 0.
//
// Ports (x = 1, 2):
//   clk, reset_n       single clock, synchronous active-low reset
//   reset_req          freezes the array and the read pipeline
//   addressx           word address (ADDR_W)
//   byteenablex        write byte lanes (DATA_W/8)
//   chipselectx, readx, writex, writedatax   Avalon-MM command
//   readdatax, readdatavalidx, waitrequestx  Avalon-MM response
//   collision          pulse: both ports wrote the same address
//   init_done          array usable (READY state)
//   parity_errx        read parity error, qualified by readdatavalidx
module fluid_board_soc_onchip_memory_dp #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 14,
  parameter int DEPTH          = 16384,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   address1,
  input  logic [DATA_W/8-1:0] byteenable1,
  input  logic                chipselect1,
  input  logic                read1,
  input  logic                write1,
  input  logic [DATA_W-1:0]   writedata1,
  output logic [DATA_W-1:0]   readdata1,
  output logic                readdatavalid1,
  output logic                waitrequest1,
  output logic                parity_err1,
  input  logic [ADDR_W-1:0]   address2,
  input  logic [DATA_W/8-1:0] byteenable2,
  input  logic                chipselect2,
  input  logic                read2,
  input  logic                write2,
  input  logic [DATA_W-1:0]   writedata2,
  output logic [DATA_W-1:0]   readdata2,
  output logic                readdatavalid2,
  output logic                waitrequest2,
  output logic                parity_err2,
  output logic                collision,
  output logic                init_done
);

  localparam int NB = DATA_W / 8;
`ifdef FLUID_ONCHIP_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + NB;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

`ifdef FLUID_ONCHIP_MEM_PARITY_EN
  // Even parity per byte lane: bit set when the byte has an odd number of ones.
  function automatic logic [NB-1:0] lane_parity(input logic [DATA_W-1:0] d);
    logic [NB-1:0] p;
    p = {NB{1'b0}};
    for (int i = 0; i < NB; i++) begin
      p[i] = ^d[i*8 +: 8];
    end
    return p;
  endfunction
`endif

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] clr_cnt;
  logic             accept_ok;
  logic             clearing;
  logic             same_addr;
  logic             collision_nxt;

  logic [MEM_W-1:0] mem [DEPTH];

  // Per-port views so both ports share one description.
  logic [ADDR_W-1:0] p_addr  [2];
  logic [NB-1:0]     p_be    [2];
  logic [DATA_W-1:0] p_wdata [2];
  logic              p_cs    [2];
  logic              p_rd    [2];
  logic              p_wr    [2];

  logic              rd_acc    [2];
  logic              wr_acc    [2];
  logic              in_range  [2];
  logic [IDX_W-1:0]  idx       [2];

  logic              mem_we    [2];
  logic [IDX_W-1:0]  mem_idx   [2];
  logic [DATA_W-1:0] mem_wdata [2];
  logic [NB-1:0]     mem_be    [2];
`ifdef FLUID_ONCHIP_MEM_PARITY_EN
  logic [NB-1:0]     mem_par   [2];
  logic [NB-1:0]     perr_lanes [2];
`endif

  logic              s1_v [2];
  logic [MEM_W-1:0]  s1_d [2];
  logic              o_v  [2];
  logic [MEM_W-1:0]  o_d  [2];

  assign p_addr[0]  = address1;
  assign p_addr[1]  = address2;
  assign p_be[0]    = byteenable1;
  assign p_be[1]    = byteenable2;
  assign p_wdata[0] = writedata1;
  assign p_wdata[1] = writedata2;
  assign p_cs[0]    = chipselect1;
  assign p_cs[1]    = chipselect2;
  assign p_rd[0]    = read1;
  assign p_rd[1]    = read2;
  assign p_wr[0]    = write1;
  assign p_wr[1]    = write2;

  assign init_done = (state == ST_READY);
  // reset_n is included so commands are refused in the very cycle reset asserts.
  assign accept_ok = reset_n & init_done & ~reset_req;
  assign clearing  = reset_n & (state == ST_CLEAR) & ~reset_req;

  assign waitrequest1 = ~accept_ok;
  assign waitrequest2 = ~accept_ok;

  // FSM next-state: RESET -> CLEAR (or READY) -> READY.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: begin
        if (CLEAR_ON_RESET != 0) begin
          state_nxt = ST_CLEAR;
        end else begin
          state_nxt = ST_READY;
        end
      end
      ST_CLEAR: begin
        if (!reset_req && (clr_cnt == LAST_IDX)) begin
          state_nxt = ST_READY;
        end else begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_RESET;
    endcase
  end

  // FSM state, clear counter and collision pulse registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_RESET;
      clr_cnt   <= {IDX_W{1'b0}};
      collision <= 1'b0;
    end else begin
      state     <= state_nxt;
      collision <= collision_nxt;
      if (clearing) begin
        clr_cnt <= (clr_cnt == LAST_IDX) ? {IDX_W{1'b0}} : clr_cnt + IDX_W'(1);
      end
    end
  end

  // Command decode; a read together with a write on one port drops the write.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_acc[p]   = accept_ok & p_cs[p] & p_rd[p];
      wr_acc[p]   = accept_ok & p_cs[p] & p_wr[p] & ~p_rd[p];
      in_range[p] = ({1'b0, p_addr[p]} < DEPTH_A);
      idx[p]      = p_addr[p][IDX_W-1:0];
    end
  end

  // Array write ports: port 1 is borrowed by the clear engine, port 2 loses ties.
  always_comb begin
    same_addr     = (p_addr[0] == p_addr[1]);
    collision_nxt = wr_acc[0] & wr_acc[1] & same_addr;
    if (clearing) begin
      mem_we[0]    = 1'b1;
      mem_idx[0]   = clr_cnt;
      mem_wdata[0] = {DATA_W{1'b0}};
      mem_be[0]    = {NB{1'b1}};
    end else begin
      mem_we[0]    = wr_acc[0] & in_range[0];
      mem_idx[0]   = idx[0];
      mem_wdata[0] = p_wdata[0];
      mem_be[0]    = p_be[0];
    end
    mem_we[1]    = wr_acc[1] & in_range[1] & ~collision_nxt;
    mem_idx[1]   = idx[1];
    mem_wdata[1] = p_wdata[1];
    mem_be[1]    = p_be[1];
`ifdef FLUID_ONCHIP_MEM_PARITY_EN
    mem_par[0] = lane_parity(mem_wdata[0]);
    mem_par[1] = lane_parity(mem_wdata[1]);
`endif
  end

  // Byte-lane masked array update.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (mem_we[p]) begin
        for (int b = 0; b < NB; b++) begin
          if (mem_be[p][b]) begin
            mem[mem_idx[p]][b*8 +: 8] <= mem_wdata[p][b*8 +: 8];
`ifdef FLUID_ONCHIP_MEM_PARITY_EN
            mem[mem_idx[p]][DATA_W+b] <= mem_par[p][b];
`endif
          end
        end
      end
    end
  end

  // First read stage; non-blocking array access gives old data on read-during-write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int p = 0; p < 2; p++) begin
        s1_v[p] <= 1'b0;
        s1_d[p] <= {MEM_W{1'b0}};
      end
    end else if (!reset_req) begin
      for (int p = 0; p < 2; p++) begin
        s1_v[p] <= rd_acc[p];
        if (rd_acc[p]) begin
          s1_d[p] <= in_range[p] ? mem[idx[p]] : {MEM_W{1'b0}};
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    // Optional output register stage, frozen together with stage one.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int p = 0; p < 2; p++) begin
          o_v[p] <= 1'b0;
          o_d[p] <= {MEM_W{1'b0}};
        end
      end else if (!reset_req) begin
        for (int p = 0; p < 2; p++) begin
          o_v[p] <= s1_v[p];
          if (s1_v[p]) begin
            o_d[p] <= s1_d[p];
          end
        end
      end
    end
  end else begin : g_lat1
    assign o_v[0] = s1_v[0];
    assign o_v[1] = s1_v[1];
    assign o_d[0] = s1_d[0];
    assign o_d[1] = s1_d[1];
  end

  // A pending pulse is hidden while frozen and shown once after release.
  assign readdata1      = o_d[0][DATA_W-1:0];
  assign readdata2      = o_d[1][DATA_W-1:0];
  assign readdatavalid1 = o_v[0] & ~reset_req;
  assign readdatavalid2 = o_v[1] & ~reset_req;

`ifdef FLUID_ONCHIP_MEM_PARITY_EN
  // Recomputed versus stored parity per lane.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      perr_lanes[p] = lane_parity(o_d[p][DATA_W-1:0]) ^ o_d[p][MEM_W-1:DATA_W];
    end
  end
  assign parity_err1 = readdatavalid1 & (|perr_lanes[0]);
  assign parity_err2 = readdatavalid2 & (|perr_lanes[1]);
`else
  assign parity_err1 = 1'b0;
  assign parity_err2 = 1'b0;
`endif

endmodule

// File: tb/tb_fluid_board_soc_onchip_memory_dp.sv
module tb_fluid_board_soc_onchip_memory_dp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 64;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              reset_n, reset_req;
  logic [ADDR_W-1:0] address1, address2;
  logic [3:0]        byteenable1, byteenable2;
  logic              chipselect1, read1, write1, chipselect2, read2, write2;
  logic [31:0]       writedata1, writedata2, readdata1, readdata2;
  logic              readdatavalid1, readdatavalid2, waitrequest1, waitrequest2;
  logic              parity_err1, parity_err2, collision, init_done;

  int n_assert = 0;
  int n_fail   = 0;
  int bad;

  always #5 clk = ~clk;

  fluid_board_soc_onchip_memory_dp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
    .address1(address1), .byteenable1(byteenable1), .chipselect1(chipselect1),
    .read1(read1), .write1(write1), .writedata1(writedata1),
    .readdata1(readdata1), .readdatavalid1(readdatavalid1),
    .waitrequest1(waitrequest1), .parity_err1(parity_err1),
    .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
    .read2(read2), .write2(write2), .writedata2(writedata2),
    .readdata2(readdata2), .readdatavalid2(readdatavalid2),
    .waitrequest2(waitrequest2), .parity_err2(parity_err2),
    .collision(collision), .init_done(init_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect1 = 1'b0; read1 = 1'b0; write1 = 1'b0;
    chipselect2 = 1'b0; read2 = 1'b0; write2 = 1'b0;
  endtask

  task automatic wr1(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect1 = 1'b1; write1 = 1'b1; read1 = 1'b0;
    address1 = a; writedata1 = d; byteenable1 = be;
  endtask

  task automatic wr2(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect2 = 1'b1; write2 = 1'b1; read2 = 1'b0;
    address2 = a; writedata2 = d; byteenable2 = be;
  endtask

  task automatic rd1(input logic [ADDR_W-1:0] a);
    chipselect1 = 1'b1; read1 = 1'b1; write1 = 1'b0; address1 = a;
  endtask

  task automatic rd2(input logic [ADDR_W-1:0] a);
    chipselect2 = 1'b1; read2 = 1'b1; write2 = 1'b0; address2 = a;
  endtask

  initial begin
    reset_n = 1'b0; reset_req = 1'b0;
    address1 = '0; address2 = '0; byteenable1 = 4'h0; byteenable2 = 4'h0;
    writedata1 = 32'h0; writedata2 = 32'h0;
    idle();
    repeat (3) tick();

    // Reset values
    check("rst_readdata1", readdata1, 32'h0);
    check("rst_rdv1", {31'h0, readdatavalid1}, 32'h0);
    check("rst_rdv2", {31'h0, readdatavalid2}, 32'h0);
    check("rst_wait1", {31'h0, waitrequest1}, 32'h1);
    check("rst_wait2", {31'h0, waitrequest2}, 32'h1);
    check("rst_collision", {31'h0, collision}, 32'h0);
    check("rst_init_done", {31'h0, init_done}, 32'h0);
    check("rst_parity_err1", {31'h0, parity_err1}, 32'h0);

    // Clear sequence: busy through cycle 64, ready at cycle 65
    reset_n = 1'b1;
    bad = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (waitrequest1 !== 1'b1 || waitrequest2 !== 1'b1 || init_done !== 1'b0) bad++;
    end
    check("clear_busy_cycles", bad, 32'd0);
    tick();
    check("clear_init_done", {31'h0, init_done}, 32'h1);
    check("clear_wait1_low", {31'h0, waitrequest1}, 32'h0);

    rd2(7'd40); tick(); idle();
    check("clear_lat_not_early", {31'h0, readdatavalid2}, 32'h0);
    tick();
    check("clear_rdv2", {31'h0, readdatavalid2}, 32'h1);
    check("clear_read_zero", readdata2, 32'h0);

    // Byte-lane write
    wr1(7'd5, 32'h11223344, 4'hF); tick();
    wr1(7'd5, 32'hAA000000, 4'h8); tick();
    rd2(7'd5); tick(); idle();
    check("bytewr_lat_not_early", {31'h0, readdatavalid2}, 32'h0);
    tick();
    check("bytewr_rdv2", {31'h0, readdatavalid2}, 32'h1);
    check("bytewr_data", readdata2, 32'hAA223344);
    check("bytewr_parity_err2", {31'h0, parity_err2}, 32'h0);
    check("bytewr_rdv1_quiet", {31'h0, readdatavalid1}, 32'h0);
    tick();
    check("bytewr_single_pulse", {31'h0, readdatavalid2}, 32'h0);

    // Collision: port 1 wins
    wr1(7'd9, 32'h1, 4'hF); wr2(7'd9, 32'h2, 4'hF); tick(); idle();
    check("coll_pulse", {31'h0, collision}, 32'h1);
    tick();
    check("coll_one_cycle", {31'h0, collision}, 32'h0);
    rd1(7'd9); tick(); idle(); tick();
    check("coll_rdv1", {31'h0, readdatavalid1}, 32'h1);
    check("coll_winner", readdata1, 32'h1);

    // Independent writes on both ports
    wr1(7'd10, 32'h000000A0, 4'hF); wr2(7'd11, 32'h000000B1, 4'hF); tick(); idle();
    check("dual_no_coll", {31'h0, collision}, 32'h0);
    rd1(7'd11); rd2(7'd10); tick(); idle(); tick();
    check("dual_rd1", readdata1, 32'h000000B1);
    check("dual_rd2", readdata2, 32'h000000A0);

    // Mixed-port read-during-write returns old data
    wr1(7'd3, 32'h7, 4'hF); tick();
    wr1(7'd3, 32'hDEAD, 4'hF); rd2(7'd3); tick(); idle(); tick();
    check("rdw_rdv2", {31'h0, readdatavalid2}, 32'h1);
    check("rdw_old", readdata2, 32'h7);
    rd2(7'd3); tick(); idle(); tick();
    check("rdw_new", readdata2, 32'hDEAD);

    // Read and write together on one port: write ignored
    chipselect1 = 1'b1; read1 = 1'b1; write1 = 1'b1;
    address1 = 7'd4; writedata1 = 32'h55; byteenable1 = 4'hF;
    tick(); idle(); tick();
    check("rdwr_rdv1", {31'h0, readdatavalid1}, 32'h1);
    check("rdwr_read", readdata1, 32'h0);
    rd1(7'd4); tick(); idle(); tick();
    check("rdwr_write_dropped", readdata1, 32'h0);

    // Out-of-range address: write ignored, read returns zero
    wr1(7'd100, 32'hBEEF, 4'hF); tick();
    rd1(7'd36); rd2(7'd100); tick(); idle(); tick();
    check("oor_no_alias", readdata1, 32'h0);
    check("oor_rdv2", {31'h0, readdatavalid2}, 32'h1);
    check("oor_read_zero", readdata2, 32'h0);

    // Stall with two reads in flight
    rd1(7'd5); tick();
    rd1(7'd9); tick();
    idle(); reset_req = 1'b1; rd2(7'd3);
    #1;
    check("stall_wait1", {31'h0, waitrequest1}, 32'h1);
    bad = 0;
    if (readdatavalid1 !== 1'b0) bad++;
    tick(); if (readdatavalid1 !== 1'b0) bad++;
    tick(); if (readdatavalid1 !== 1'b0) bad++;
    tick(); if (readdatavalid1 !== 1'b0) bad++;
    check("stall_no_valid", bad, 32'd0);
    reset_req = 1'b0; idle();
    #1;
    check("stall_first_valid", {31'h0, readdatavalid1}, 32'h1);
    check("stall_first_data", readdata1, 32'hAA223344);
    tick();
    check("stall_second_valid", {31'h0, readdatavalid1}, 32'h1);
    check("stall_second_data", readdata1, 32'h1);
    tick();
    check("stall_no_dup", {31'h0, readdatavalid1}, 32'h0);
    check("stall_rd2_refused", {31'h0, readdatavalid2}, 32'h0);

    // Reset with a read in flight discards it
    rd1(7'd9); tick(); idle();
    reset_n = 1'b0; tick();
    check("rstfl_rdv1", {31'h0, readdatavalid1}, 32'h0);
    check("rstfl_readdata1", readdata1, 32'h0);
    check("rstfl_init_done", {31'h0, init_done}, 32'h0);
    check("rstfl_wait1", {31'h0, waitrequest1}, 32'h1);

    // Reset mid-clear restarts the counter
    reset_n = 1'b1;
    repeat (30) tick();
    check("midclr_busy", {31'h0, init_done}, 32'h0);
    reset_n = 1'b0; tick(); tick();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (init_done !== 1'b0) bad++;
    end
    check("midclr_restart", bad, 32'd0);
    tick();
    check("midclr_init_done", {31'h0, init_done}, 32'h1);
    rd1(7'd5); tick(); idle(); tick();
    check("midclr_rdv1", {31'h0, readdatavalid1}, 32'h1);
    check("midclr_cleared", readdata1, 32'h0);

`ifdef FLUID_ONCHIP_MEM_PARITY_EN
    // Corrupt one stored bit and read it back
    dut.mem[2] = dut.mem[2] ^ 36'h1;
    rd1(7'd2); tick(); idle(); tick();
    check("parity_rdv1", {31'h0, readdatavalid1}, 32'h1);
    check("parity_err_flag", {31'h0, parity_err1}, 32'h1);
`else
    rd1(7'd2); tick(); idle(); tick();
    check("parity_rdv1", {31'h0, readdatavalid1}, 32'h1);
    check("parity_err_tied", {31'h0, parity_err1}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
